// File: rtl/two_digit_encoder_pkg.sv
// Shared constants for the two-digit entry path of the game.
// Holds the entry FSM state encoding, the default ceiling on an accepted
// result, and the decimal-to-binary combine used when both digits are in.
package two_digit_encoder_pkg;

   // The three phases of a two-key entry: collect tens, collect ones, combine.
   typedef enum logic [1:0] {
      WAIT_TENS = 2'd0,
      WAIT_ONES = 2'd1,
      CALC      = 2'd2
   } entry_state_t;

   // Largest result an entry may produce unless the instance overrides it.
   localparam int DEFAULT_MAX_VALUE = 63;

   // Largest legal BCD digit; anything above this is a rejected key.
   localparam logic [3:0] MAX_DIGIT = 4'd9;

   // tens*10 + ones without a multiplier: tens*8 + tens*2 + ones.
   // Seven bits are enough because 9*10 + 9 = 99.
   function automatic logic [6:0] calc_sum(input logic [3:0] tens_digit,
                                           input logic [3:0] ones_digit);
      logic [6:0] tens_wide;
      tens_wide = {3'b000, tens_digit};
      return (tens_wide << 3) + (tens_wide << 1) + {3'b000, ones_digit};
   endfunction

endpackage

// File: rtl/two_digit_encoder_key_edge.sv
// key_edge: turns a level key input into a single-cycle pulse on its rising
// edge. Shared by every game key so they all behave the same way.
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous active-high reset
//   level  - raw key level, active-high
//   pulse  - high for one cycle when level is high and was low last cycle
module key_edge (
   input  logic clock,
   input  logic reset,
   input  logic level,
   output logic pulse
);

   logic level_q;

   // Remember last cycle's key level. Clearing it on reset means a key that
   // is already held when reset releases still counts as one press.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         level_q <= 1'b0;
      end else begin
         level_q <= level;
      end
   end

   // A press is "high now, low before"; holding the key gives only one pulse.
   assign pulse = level & ~level_q;

endmodule

// File: rtl/two_digit_encoder.sv
// two_digit_encoder: collects a tens digit and a ones digit from BCD
// switches, one enter press each, and produces the binary value
// tens*10 + ones. Out-of-range digits or results are rejected with an
// error pulse and leave the last good value in place.
// Ports:
//   clock   - system clock, rising edge
//   reset   - asynchronous active-high reset
//   enable  - high: enter presses are accepted; low: they are ignored
//   clear   - synchronous abort; drops a partial entry and zeroes value
//   digit   - BCD digit from the switches, sampled on an accepted press
//   enter   - enter key level, only its rising edge acts
//   value   - last accepted binary result
//   valid   - one-cycle pulse when value updates
//   error   - one-cycle pulse when an entry is rejected
//   pending - high while the tens digit is held and ones is awaited
//   tens    - held tens digit for display feedback, 0 when not pending
module two_digit_encoder #(
   parameter int MAX_VALUE = two_digit_encoder_pkg::DEFAULT_MAX_VALUE
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       clear,
   input  logic [3:0] digit,
   input  logic       enter,
   output logic [5:0] value,
   output logic       valid,
   output logic       error,
   output logic       pending,
   output logic [3:0] tens
);

   import two_digit_encoder_pkg::*;

   localparam logic [6:0] MAX_SUM = 7'(MAX_VALUE);

   entry_state_t state;
   entry_state_t state_next;

   logic       enter_edge;
   logic       accept;
   logic       digit_ok;
   logic [6:0] sum;

   logic [3:0] tens_held;
   logic [3:0] ones_held;
   logic [3:0] tens_next;
   logic [3:0] ones_next;
   logic [5:0] value_next;
   logic       valid_next;
   logic       error_next;

   key_edge u_enter_edge (
      .clock (clock),
      .reset (reset),
      .level (enter),
      .pulse (enter_edge)
   );

   // A press only counts while enabled and while waiting for a digit; a
   // press landing during the combine cycle is dropped on purpose.
   assign accept   = enter_edge & enable & (state != CALC);
   assign digit_ok = (digit <= MAX_DIGIT);
   assign sum      = calc_sum(tens_held, ones_held);

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= WAIT_TENS;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. A bad digit in either wait state restarts the entry,
   // the combine cycle always falls back to collecting tens, and clear wins
   // over everything else.
   always_comb begin
      state_next = state;
      if (clear) begin
         state_next = WAIT_TENS;
      end else begin
         case (state)
            WAIT_TENS: if (accept) state_next = digit_ok ? WAIT_ONES : WAIT_TENS;
            WAIT_ONES: if (accept) state_next = digit_ok ? CALC : WAIT_TENS;
            CALC:      state_next = WAIT_TENS;
            default:   state_next = WAIT_TENS;
         endcase
      end
   end

   // Datapath next values. Digits are captured on accepted presses, the
   // result is formed in the combine cycle, and valid/error are computed
   // here so that both come out as registered one-cycle pulses. Only one
   // branch can raise a pulse per cycle, so valid and error never overlap.
   always_comb begin
      tens_next  = tens_held;
      ones_next  = ones_held;
      value_next = value;
      valid_next = 1'b0;
      error_next = 1'b0;
      if (clear) begin
         tens_next  = 4'd0;
         ones_next  = 4'd0;
         value_next = 6'd0;
      end else begin
         case (state)
            WAIT_TENS: begin
               if (accept) begin
                  if (digit_ok) begin
                     tens_next = digit;
                  end else begin
                     tens_next  = 4'd0;
                     error_next = 1'b1;
                  end
               end
            end
            WAIT_ONES: begin
               if (accept) begin
                  if (digit_ok) begin
                     ones_next = digit;
                  end else begin
                     tens_next  = 4'd0;
                     error_next = 1'b1;
                  end
               end
            end
            CALC: begin
               if (sum <= MAX_SUM) begin
                  value_next = sum[5:0];
                  valid_next = 1'b1;
               end else begin
                  error_next = 1'b1;
               end
               tens_next = 4'd0;
               ones_next = 4'd0;
            end
            default: begin
               tens_next = 4'd0;
               ones_next = 4'd0;
            end
         endcase
      end
   end

   // Datapath registers; reset drops any entry in flight without a pulse.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tens_held <= 4'd0;
         ones_held <= 4'd0;
         value     <= 6'd0;
         valid     <= 1'b0;
         error     <= 1'b0;
      end else begin
         tens_held <= tens_next;
         ones_held <= ones_next;
         value     <= value_next;
         valid     <= valid_next;
         error     <= error_next;
      end
   end

   // Display-side outputs follow the state directly.
   always_comb begin
      pending = (state == WAIT_ONES);
      tens    = pending ? tens_held : 4'd0;
   end

endmodule
